// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: position counters, sync/blank, selectable
// colour patterns, with mode changes deferred to the frame boundary.
module vga_pattern_gen #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int CNT_W           = 10,
  parameter int COLOR_BITS      = 3,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic [2:0]            i_Mode,
  input  logic                  i_Mode_Valid,
  output logic                  o_HSync,
  output logic                  o_VSync,
  output logic [COLOR_BITS-1:0] o_Red,
  output logic [COLOR_BITS-1:0] o_Grn,
  output logic [COLOR_BITS-1:0] o_Blu,
  output logic                  o_Visible,
  output logic [CNT_W-1:0]      o_HPos,
  output logic [CNT_W-1:0]      o_VPos,
  output logic                  o_Frame_Start,
  output logic [2:0]            o_Mode
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_W   = CNT_W'(H_ACTIVE / 8);
  localparam logic [COLOR_BITS-1:0] C_ONES = '1;

  logic [CNT_W-1:0] h_q, v_q;
  logic [7:0]       frame_q;
  logic [2:0]       mode_q;
  logic             pend_q;
  logic [2:0]       pend_mode_q;

  logic                  h_last, v_last, visible_d, hsync_d, vsync_d, chk_on;
  logic [2:0]            bar;
  logic [COLOR_BITS-1:0] red_d, grn_d, blu_d;

  always_comb begin
    h_last    = (h_q == H_LAST);
    v_last    = (v_q == V_LAST);
    visible_d = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    hsync_d   = ((h_q >= HS_BEG) && (h_q < HS_END)) ^ SYNC_ACTIVE_LOW;
    vsync_d   = ((v_q >= VS_BEG) && (v_q < VS_END)) ^ SYNC_ACTIVE_LOW;
    bar       = 3'(h_q / BAR_W);
    // Adding the frame count to h scrolls the checker one pixel left per frame.
    chk_on    = 1'((h_q + CNT_W'(frame_q)) >> 4) ^ v_q[4];
    red_d     = '0;
    grn_d     = '0;
    blu_d     = '0;
    case (mode_q)
      3'd1: begin
        red_d = {COLOR_BITS{(h_q[2:0] == 3'd0) || (v_q[2:0] == 3'd0)}};
        grn_d = {COLOR_BITS{v_q[4]}};
        blu_d = {COLOR_BITS{h_q[4]}};
      end
      3'd2: begin
        red_d = {COLOR_BITS{~bar[1]}};
        grn_d = {COLOR_BITS{~bar[2]}};
        blu_d = {COLOR_BITS{~bar[0]}};
      end
      3'd3: begin
        red_d = COLOR_BITS'(h_q >> 4);
        grn_d = COLOR_BITS'(h_q >> 4);
        blu_d = COLOR_BITS'(h_q >> 4);
      end
      3'd4: begin
        red_d = {COLOR_BITS{chk_on}};
        grn_d = {COLOR_BITS{chk_on}};
        blu_d = {COLOR_BITS{chk_on}};
      end
      3'd5: begin
        red_d = C_ONES;
        grn_d = C_ONES;
        blu_d = C_ONES;
      end
      default: ;
    endcase
    if (!visible_d) begin
      red_d = '0;
      grn_d = '0;
      blu_d = '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      h_q           <= '0;
      v_q           <= '0;
      frame_q       <= '0;
      mode_q        <= 3'd1;
      pend_q        <= 1'b0;
      pend_mode_q   <= 3'd0;
      o_HSync       <= SYNC_ACTIVE_LOW;
      o_VSync       <= SYNC_ACTIVE_LOW;
      o_Red         <= '0;
      o_Grn         <= '0;
      o_Blu         <= '0;
      o_Visible     <= 1'b0;
      o_HPos        <= '0;
      o_VPos        <= '0;
      o_Frame_Start <= 1'b0;
      o_Mode        <= 3'd1;
    end else begin
      if (h_last) begin
        h_q <= '0;
        if (v_last) begin
          v_q     <= '0;
          frame_q <= frame_q + 8'd1;
        end else begin
          v_q <= v_q + 1'b1;
        end
      end else begin
        h_q <= h_q + 1'b1;
      end
      // A strobe on the boundary cycle must survive the clear, so it is written last.
      if (h_last && v_last && pend_q) begin
        mode_q <= pend_mode_q;
        pend_q <= 1'b0;
      end
      if (i_Mode_Valid) begin
        pend_q      <= 1'b1;
        pend_mode_q <= i_Mode;
      end
      o_HSync       <= hsync_d;
      o_VSync       <= vsync_d;
      o_Red         <= red_d;
      o_Grn         <= grn_d;
      o_Blu         <= blu_d;
      o_Visible     <= visible_d;
      o_HPos        <= h_q;
      o_VPos        <= v_q;
      o_Frame_Start <= (h_q == '0) && (v_q == '0);
      o_Mode        <= mode_q;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: a tiny-timing instance for sync/mode behaviour and a 640-wide
// instance (short vertical) for colour-bar and grey-ramp columns.
module tb_vga_pattern_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] mode_s, mode_w;
  logic       mv_s, mv_w;
  logic       hs_s, vs_s, vis_s, fs_s, hs_w, vs_w, vis_w, fs_w;
  logic [2:0] r_s, g_s, b_s, r_w, g_w, b_w, mo_s, mo_w;
  logic [9:0] hp_s, vp_s, hp_w, vp_w;

  vga_pattern_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .CNT_W(10), .COLOR_BITS(3), .SYNC_ACTIVE_LOW(1'b1)) dut_s (
    .i_Clk(clk), .i_Reset(rst), .i_Mode(mode_s), .i_Mode_Valid(mv_s),
    .o_HSync(hs_s), .o_VSync(vs_s), .o_Red(r_s), .o_Grn(g_s), .o_Blu(b_s),
    .o_Visible(vis_s), .o_HPos(hp_s), .o_VPos(vp_s), .o_Frame_Start(fs_s), .o_Mode(mo_s));

  vga_pattern_gen #(.H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
                    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .CNT_W(10), .COLOR_BITS(3), .SYNC_ACTIVE_LOW(1'b1)) dut_w (
    .i_Clk(clk), .i_Reset(rst), .i_Mode(mode_w), .i_Mode_Valid(mv_w),
    .o_HSync(hs_w), .o_VSync(vs_w), .o_Red(r_w), .o_Grn(g_w), .o_Blu(b_w),
    .o_Visible(vis_w), .o_HPos(hp_w), .o_VPos(vp_w), .o_Frame_Start(fs_w), .o_Mode(mo_w));

  int total = 0;
  int bad = 0;
  logic [7:0] nfs = 8'd0;  // number of the next frame of the small instance
  logic [7:0] frm = 8'd0;  // number of the frame currently on the small outputs

  task automatic tick();
    logic r;
    @(posedge clk);
    r = rst;
    #1;
    if (r) nfs = 8'd0;
    else if (fs_s) begin
      frm = nfs;
      nfs = nfs + 8'd1;
    end
  endtask

  task automatic wait_fs_s(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (fs_s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mv_s = 1'b0; mv_w = 1'b0; mode_s = 3'd0; mode_w = 3'd0;
    tick(); tick();
    total++; if (hs_s !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b exp=1", hs_s); end
    total++; if (vs_s !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b exp=1", vs_s); end
    total++; if ({r_s, g_s, b_s} !== 9'o000) begin bad++; $display("FAIL reset_rgb got=%o exp=0", {r_s, g_s, b_s}); end
    total++; if (vis_s !== 1'b0) begin bad++; $display("FAIL reset_visible got=%b exp=0", vis_s); end
    total++; if ({hp_s, vp_s} !== 20'd0) begin bad++; $display("FAIL reset_pos got=%0d,%0d exp=0,0", hp_s, vp_s); end
    total++; if (fs_s !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b exp=0", fs_s); end
    total++; if (mo_s !== 3'd1) begin bad++; $display("FAIL reset_mode got=%0d exp=1", mo_s); end
    rst = 1'b0;
    tick();
    total++; if (fs_s !== 1'b1) begin bad++; $display("FAIL first_fs got=%b exp=1", fs_s); end
    total++; if ({hp_s, vp_s} !== 20'd0) begin bad++; $display("FAIL first_pos got=%0d,%0d exp=0,0", hp_s, vp_s); end
    total++; if (r_s !== 3'd7) begin bad++; $display("FAIL first_red got=%0d exp=7", r_s); end
  endtask

  // Walks one whole frame of the small instance in default grid mode.
  task automatic test_timing();
    int h, v;
    logic ehs, evs, evis;
    logic [8:0] ergb;
    for (int c = 0; c < 288; c++) begin
      h = c % 24; v = c / 24;
      ehs  = !(h >= 18 && h < 21);
      evs  = !(v >= 9 && v < 11);
      evis = (h < 16) && (v < 8);
      ergb = 9'o000;
      if (evis) begin
        ergb[8:6] = ((h % 8 == 0) || (v % 8 == 0)) ? 3'd7 : 3'd0;
        ergb[5:3] = ((v / 16) % 2 == 1) ? 3'd7 : 3'd0;
        ergb[2:0] = ((h / 16) % 2 == 1) ? 3'd7 : 3'd0;
      end
      total++; if (hp_s !== 10'(h) || vp_s !== 10'(v)) begin bad++; $display("FAIL timing_pos c=%0d got=%0d,%0d exp=%0d,%0d", c, hp_s, vp_s, h, v); end
      total++; if (hs_s !== ehs) begin bad++; $display("FAIL timing_hsync c=%0d got=%b exp=%b", c, hs_s, ehs); end
      total++; if (vs_s !== evs) begin bad++; $display("FAIL timing_vsync c=%0d got=%b exp=%b", c, vs_s, evs); end
      total++; if (vis_s !== evis) begin bad++; $display("FAIL timing_visible c=%0d got=%b exp=%b", c, vis_s, evis); end
      total++; if (fs_s !== (c == 0)) begin bad++; $display("FAIL timing_fs c=%0d got=%b exp=%b", c, fs_s, c == 0); end
      total++; if ({r_s, g_s, b_s} !== ergb) begin bad++; $display("FAIL timing_grid c=%0d got=%o exp=%o", c, {r_s, g_s, b_s}, ergb); end
      tick();
    end
    total++; if (fs_s !== 1'b1) begin bad++; $display("FAIL frame_period got=%b exp=1", fs_s); end
  endtask

  task automatic test_wide();
    int hl2[5] = '{0, 79, 80, 400, 639};
    logic [8:0] el2[5] = '{9'o777, 9'o777, 9'o770, 9'o700, 9'o000};
    int hl3[5] = '{0, 16, 127, 128, 640};
    logic [8:0] el3[5] = '{9'o000, 9'o111, 9'o777, 9'o000, 9'o000};
    bit ok;
    for (int m = 2; m <= 3; m++) begin
      mode_w = 3'(m); mv_w = 1'b1; tick(); mv_w = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 4500; i++) begin
        tick();
        if (fs_w) begin ok = 1'b1; break; end
      end
      total++; if (!ok) begin bad++; $display("FAIL wide_fs_timeout mode=%0d got=none exp=pulse", m); end
      total++; if (mo_w !== 3'(m)) begin bad++; $display("FAIL wide_mode got=%0d exp=%0d", mo_w, m); end
      for (int h = 0; h <= 640; h++) begin
        for (int k = 0; k < 5; k++) begin
          if ((m == 2 && hl2[k] == h) || (m == 3 && hl3[k] == h)) begin
            total++;
            if (hp_w !== 10'(h) || {r_w, g_w, b_w} !== (m == 2 ? el2[k] : el3[k])) begin
              bad++;
              $display("FAIL wide_colour mode=%0d h=%0d got=%o@%0d exp=%o", m, h, {r_w, g_w, b_w}, hp_w, m == 2 ? el2[k] : el3[k]);
            end
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_checker();
    bit ok, saw255, done;
    logic [8:0] e;
    int sum;
    repeat (30) tick();
    mode_s = 3'd4; mv_s = 1'b1; tick(); mv_s = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (fs_s) begin ok = 1'b1; break; end
      total++; if (mo_s !== 3'd1) begin bad++; $display("FAIL early_mode got=%0d exp=1", mo_s); end
    end
    total++; if (!ok) begin bad++; $display("FAIL chk_fs_timeout got=none exp=pulse"); end
    saw255 = 1'b0; done = 1'b0;
    for (int f = 0; f < 270 && !done; f++) begin
      total++; if (mo_s !== 3'd4) begin bad++; $display("FAIL chk_mode frame=%0d got=%0d exp=4", frm, mo_s); end
      for (int h = 0; h < 16; h++) begin
        sum = h + int'(frm);
        e = ((sum / 16) % 2 == 1) ? 9'o777 : 9'o000;
        total++; if ({r_s, g_s, b_s} !== e) begin bad++; $display("FAIL checker frame=%0d h=%0d got=%o exp=%o", frm, h, {r_s, g_s, b_s}, e); end
        tick();
      end
      if (frm == 8'd255) saw255 = 1'b1;
      if (saw255 && frm == 8'd2) done = 1'b1;
      else begin
        wait_fs_s(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL chk_next_fs got=none exp=pulse"); end
      end
    end
    total++; if (!done) begin bad++; $display("FAIL frame_wrap got=unseen exp=seen"); end
  endtask

  task automatic test_last_wins();
    bit ok;
    repeat (5) tick();
    mode_s = 3'd2; mv_s = 1'b1; tick(); mv_s = 1'b0;
    repeat (10) tick();
    mode_s = 3'd5; mv_s = 1'b1; tick(); mv_s = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (fs_s) begin ok = 1'b1; break; end
      total++; if (mo_s !== 3'd4) begin bad++; $display("FAIL midframe_mode got=%0d exp=4", mo_s); end
    end
    total++; if (!ok) begin bad++; $display("FAIL last_fs_timeout got=none exp=pulse"); end
    total++; if (mo_s !== 3'd5) begin bad++; $display("FAIL last_wins got=%0d exp=5", mo_s); end
    total++; if ({r_s, g_s, b_s} !== 9'o777) begin bad++; $display("FAIL white got=%o exp=777", {r_s, g_s, b_s}); end
  endtask

  task automatic test_boundary();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (hp_s == 10'd22 && vp_s == 10'd11) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL bnd_seek got=none exp=22,11"); end
    mode_s = 3'd2; mv_s = 1'b1; tick(); mv_s = 1'b0;
    total++; if (mo_s !== 3'd5) begin bad++; $display("FAIL bnd_mode_pre got=%0d exp=5", mo_s); end
    tick();
    total++; if (fs_s !== 1'b1 || mo_s !== 3'd5) begin bad++; $display("FAIL bnd_same_frame got=%b/%0d exp=1/5", fs_s, mo_s); end
    wait_fs_s(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL bnd_fs_timeout got=none exp=pulse"); end
    total++; if (mo_s !== 3'd2) begin bad++; $display("FAIL bnd_applied got=%0d exp=2", mo_s); end
    total++; if ({r_s, g_s, b_s} !== 9'o777) begin bad++; $display("FAIL bar0 got=%o exp=777", {r_s, g_s, b_s}); end
    tick(); tick();
    total++; if ({r_s, g_s, b_s} !== 9'o770) begin bad++; $display("FAIL bar1 got=%o exp=770", {r_s, g_s, b_s}); end
    repeat (13) tick();
    total++; if ({r_s, g_s, b_s} !== 9'o000) begin bad++; $display("FAIL bar7 got=%o exp=000", {r_s, g_s, b_s}); end
  endtask

  task automatic test_reset_mid();
    repeat (5) tick();
    mode_s = 3'd3; mv_s = 1'b1; tick(); mv_s = 1'b0;
    repeat (3) tick();
    rst = 1'b1; tick();
    total++; if ({hs_s, vs_s, vis_s, fs_s} !== 4'b1100) begin bad++; $display("FAIL mid_reset_ctl got=%b exp=1100", {hs_s, vs_s, vis_s, fs_s}); end
    total++; if ({r_s, g_s, b_s} !== 9'o000 || {hp_s, vp_s} !== 20'd0) begin bad++; $display("FAIL mid_reset_px got=%o@%0d,%0d exp=0@0,0", {r_s, g_s, b_s}, hp_s, vp_s); end
    total++; if (mo_s !== 3'd1) begin bad++; $display("FAIL mid_reset_mode got=%0d exp=1", mo_s); end
    rst = 1'b0; tick();
    total++; if (fs_s !== 1'b1) begin bad++; $display("FAIL mid_restart_fs got=%b exp=1", fs_s); end
    for (int i = 0; i < 600; i++) begin
      total++; if (mo_s !== 3'd1) begin bad++; $display("FAIL discarded_pending i=%0d got=%0d exp=1", i, mo_s); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_wide();
    test_checker();
    test_last_wins();
    test_boundary();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
